// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC and IR, runs a req/ack read per fetch_req pulse; fetch_req->mem_req 1 cycle, ack->instr 1 cycle.
// No backpressure: fetch_req while busy is ignored; branch/clear mid-fetch discards the in-flight word and refetches.
module fetch_unit #(
    parameter int          ADDR_W   = 11,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              load_pc,
    input  logic [31:0]       branch_addr,
    input  logic              clear_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       instr,
    output logic [31:0]       pc,
    output logic              instr_valid,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [31:0]       pc_n;
    logic [31:0]       instr_n;
    logic              instr_valid_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        cnt, cnt_n;
    logic              drop, drop_n;
    logic              fetch_err_n;
    logic              redirect;

    // Low address bits of a branch target are always forced to zero.
    logic unused_branch_lsbs;
    assign unused_branch_lsbs = &{1'b0, branch_addr[1:0]};

    assign redirect = clear_pc | load_pc;

    // mem_req is high for the whole outstanding request (REQ and WAIT).
    assign busy    = (state != IDLE);
    assign mem_req = (state != IDLE);

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_n       = instr;
        instr_valid_n = instr_valid;
        mem_addr_n    = mem_addr;
        cnt_n         = cnt;
        drop_n        = drop;
        fetch_err_n   = 1'b0;

        if (clear_pc) begin
            pc_n = RESET_PC;
        end else if (load_pc) begin
            pc_n = {branch_addr[31:2], 2'b00};
        end

        case (state)
            IDLE: begin
                if (fetch_req) begin
                    instr_valid_n = 1'b0;
                    mem_addr_n    = pc_n[ADDR_W+1:2];
                    cnt_n         = 8'd0;
                    drop_n        = 1'b0;
                    state_n       = REQ;
                end
            end
            REQ, WAIT: begin
                if (redirect) begin
                    drop_n = 1'b1;
                end
                if (mem_ack) begin
                    if (drop || redirect) begin
                        // Stale word: reissue at the redirected PC.
                        drop_n     = 1'b0;
                        mem_addr_n = pc_n[ADDR_W+1:2];
                        cnt_n      = 8'd0;
                        state_n    = REQ;
                    end else begin
                        instr_n       = mem_rdata;
                        instr_valid_n = 1'b1;
                        pc_n          = pc + 32'd4;
                        state_n       = IDLE;
                    end
                end else if (state == REQ) begin
                    cnt_n   = 8'd0;
                    state_n = WAIT;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    fetch_err_n = 1'b1;
                    drop_n      = 1'b0;
                    cnt_n       = 8'd0;
                    state_n     = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            mem_addr    <= '0;
            cnt         <= 8'd0;
            drop        <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_valid <= instr_valid_n;
            mem_addr    <= mem_addr_n;
            cnt         <= cnt_n;
            drop        <= drop_n;
            fetch_err   <= fetch_err_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected requests/completions/errors, a negedge monitor pops and compares.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        load_pc;
    logic [31:0] branch_addr;
    logic        clear_pc;
    logic        mem_req;
    logic [10:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        busy;
    logic        fetch_err;

    fetch_unit #(.ADDR_W(11), .RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .load_pc     (load_pc),
        .branch_addr (branch_addr),
        .clear_pc    (clear_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instr       (instr),
        .pc          (pc),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } done_t;

    logic [31:0] exp_addr[$];
    done_t       exp_done[$];
    logic [31:0] exp_err[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: a new request is mem_req rising, or mem_req still high right after an ack.
    logic  prev_req = 1'b0;
    logic  prev_ack = 1'b0;
    logic  prev_iv  = 1'b0;
    always @(negedge clk) begin
        logic [31:0] ea;
        done_t       ed;
        if (!rst) begin
            if (mem_req && (!prev_req || prev_ack)) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    failures++;
                    $display("FAIL unexp_req: got request at addr %h, required none", mem_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    check("req_addr", {21'h0, mem_addr}, ea);
                end
            end
            if (instr_valid && !prev_iv) begin
                checks++;
                if (exp_done.size() == 0) begin
                    failures++;
                    $display("FAIL unexp_done: got instr %h, required none", instr);
                end else begin
                    ed = exp_done.pop_front();
                    check("done_instr", instr, ed.instr);
                    check("done_pc", pc, ed.pc);
                end
            end
            if (fetch_err) begin
                checks++;
                if (exp_err.size() == 0) begin
                    failures++;
                    $display("FAIL unexp_err: got fetch_err at pc %h, required none", pc);
                end else begin
                    ea = exp_err.pop_front();
                    check("err_pc", pc, ea);
                end
            end
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_iv  = instr_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after the pulse was sampled (DUT in REQ).
    task automatic pulse_fetch();
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] data);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic branch_to(input logic [31:0] addr);
        tick();
        load_pc     = 1'b1;
        branch_addr = addr;
        tick();
        load_pc     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_err;
        int n_err;

        rst = 1'b1; fetch_req = 1'b0; load_pc = 1'b0; clear_pc = 1'b0;
        branch_addr = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_iv", {31'h0, instr_valid}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, fetch_err}, 32'h0);

        // Zero-wait fetch: ack in the first request cycle.
        exp_addr.push_back(32'h0);
        exp_done.push_back('{instr: 32'hE3A0_1005, pc: 32'h4});
        pulse_fetch();
        check("t1_mem_req", {31'h0, mem_req}, 32'h1);
        ack_now(32'hE3A0_1005);
        check("t1_instr", instr, 32'hE3A0_1005);
        check("t1_iv", {31'h0, instr_valid}, 32'h1);
        check("t1_pc", pc, 32'h4);
        check("t1_busy", {31'h0, busy}, 32'h0);

        // Five wait states.
        exp_addr.push_back(32'h1);
        exp_done.push_back('{instr: 32'h1234_5678, pc: 32'h8});
        pulse_fetch();
        check("t2_iv_clr", {31'h0, instr_valid}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("t2_req_held", {31'h0, mem_req}, 32'h1);
            check("t2_addr_stable", {21'h0, mem_addr}, 32'h1);
            check("t2_no_err", {31'h0, fetch_err}, 32'h0);
            tick();
        end
        ack_now(32'h1234_5678);
        check("t2_instr", instr, 32'h1234_5678);
        check("t2_pc", pc, 32'h8);
        check("t2_err", {31'h0, fetch_err}, 32'h0);

        // Branch while waiting: old word discarded, refetch at 0x100.
        exp_addr.push_back(32'h2);
        exp_addr.push_back(32'h40);
        exp_done.push_back('{instr: 32'hA5A5_0001, pc: 32'h104});
        pulse_fetch();
        tick();
        load_pc = 1'b1; branch_addr = 32'h0000_0103;
        tick();
        load_pc = 1'b0;
        check("t3_pc_now", pc, 32'h100);
        check("t3_busy", {31'h0, busy}, 32'h1);
        ack_now(32'hDEAD_0000);
        check("t3_instr_kept", instr, 32'h1234_5678);
        check("t3_iv_low", {31'h0, instr_valid}, 32'h0);
        check("t3_refetch_req", {31'h0, mem_req}, 32'h1);
        check("t3_refetch_addr", {21'h0, mem_addr}, 32'h40);
        ack_now(32'hA5A5_0001);
        check("t3_instr", instr, 32'hA5A5_0001);
        check("t3_pc", pc, 32'h104);

        // Timeout: no ack ever.
        exp_addr.push_back(32'h41);
        exp_err.push_back(32'h104);
        pulse_fetch();
        first_err = -1;
        n_err = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (fetch_err) begin
                n_err++;
                if (first_err < 0) first_err = k;
            end
        end
        check("t4_err_cycle", first_err, 32'd16);
        check("t4_err_count", n_err, 32'd1);
        check("t4_busy", {31'h0, busy}, 32'h0);
        check("t4_mem_req", {31'h0, mem_req}, 32'h0);
        check("t4_pc", pc, 32'h104);
        check("t4_instr", instr, 32'hA5A5_0001);
        check("t4_iv", {31'h0, instr_valid}, 32'h0);

        // clear_pc beats load_pc.
        branch_to(32'h20);
        check("t5_pc_20", pc, 32'h20);
        tick();
        clear_pc = 1'b1; load_pc = 1'b1; branch_addr = 32'h300;
        tick();
        clear_pc = 1'b0; load_pc = 1'b0;
        check("t5_clear_wins", pc, 32'h0);

        // fetch_req while busy is ignored.
        exp_addr.push_back(32'h0);
        exp_done.push_back('{instr: 32'h1111_2222, pc: 32'h4});
        pulse_fetch();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        check("t5_addr_busy", {21'h0, mem_addr}, 32'h0);
        ack_now(32'h1111_2222);
        repeat (3) tick();
        check("t5_no_second_busy", {31'h0, busy}, 32'h0);
        check("t5_no_second_req", {31'h0, mem_req}, 32'h0);
        check("t5_pc", pc, 32'h4);

        // Branch in the same cycle as fetch_req: fetch uses the new PC.
        exp_addr.push_back(32'h1FF);
        exp_done.push_back('{instr: 32'h3333_4444, pc: 32'h800});
        tick();
        fetch_req = 1'b1; load_pc = 1'b1; branch_addr = 32'h0000_07FC;
        tick();
        fetch_req = 1'b0; load_pc = 1'b0;
        check("t5_same_cycle_addr", {21'h0, mem_addr}, 32'h1FF);
        ack_now(32'h3333_4444);
        check("t5_same_cycle_pc", pc, 32'h800);

        // PC wrap and mem_addr truncation.
        branch_to(32'hFFFF_FFFF);
        check("t5_pc_align", pc, 32'hFFFF_FFFC);
        exp_addr.push_back(32'h7FF);
        exp_done.push_back('{instr: 32'h5555_6666, pc: 32'h0});
        pulse_fetch();
        check("t5_trunc_addr", {21'h0, mem_addr}, 32'h7FF);
        ack_now(32'h5555_6666);
        check("t5_wrap_pc", pc, 32'h0);

        // Reset mid-WAIT, then a late ack.
        branch_to(32'h50);
        exp_addr.push_back(32'h14);
        pulse_fetch();
        tick();
        check("t6_waiting", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_mem_req", {31'h0, mem_req}, 32'h0);
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_pc", pc, 32'h0);
        check("t6_instr", instr, 32'h0);
        check("t6_iv", {31'h0, instr_valid}, 32'h0);
        ack_now(32'h0BAD_0BAD);
        tick();
        check("t6_late_instr", instr, 32'h0);
        check("t6_late_iv", {31'h0, instr_valid}, 32'h0);
        check("t6_late_busy", {31'h0, busy}, 32'h0);
        check("t6_late_pc", pc, 32'h0);

        repeat (2) tick();
        check("q_addr_empty", exp_addr.size(), 32'd0);
        check("q_done_empty", exp_done.size(), 32'd0);
        check("q_err_empty", exp_err.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
